instr_encoder_loader: RTL and testbench

- Inverse of the instruction field decoder. Accepts instruction fields (opcode, register numbers, immediate, offset) over a valid/ready handshake.
- Packs the fields into the 32-bit encoded instruction word and buffers each word in a small FIFO.
- Writes the words sequentially into instruction memory through a busywait-style write port.
- Used by the boot/test loader to fill instruction memory before the CPU is released from reset.

---
 rtl/instr_encoder_loader.sv | 162 ++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Packs instruction fields into 32-bit words, queues them in a small FIFO and streams them
// into instruction memory over a busywait write port. Optional opcode check: ENC_OPCODE_CHECK_EN.
module instr_encoder_loader #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_WIDTH  = 10,
  parameter int NUM_OPCODES = 12
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [1:0]            FORMAT,
  input  logic [7:0]            OPCODE,
  input  logic [2:0]            WRITEREG,
  input  logic [2:0]            READREG1,
  input  logic [2:0]            READREG2,
  input  logic [7:0]            IMMEDIATE,
  input  logic [7:0]            OFFSET,
  input  logic                  BASE_LOAD,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic [31:0]           MEM_WRITEDATA,
  input  logic                  MEM_BUSYWAIT,
  output logic [15:0]           WORD_COUNT,
  output logic                  IDLE,
  output logic                  ERR
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || ADDR_WIDTH < 3 ||
      NUM_OPCODES < 1 || NUM_OPCODES > 256) begin : g_param_check
    $error("instr_encoder_loader: illegal parameter combination");
  end

  typedef enum logic {S_IDLE, S_WRITE} state_t;
  state_t state_q, state_d;

  logic [7:0]  b_hi, b_mid, b_lo;
  logic [31:0] word;
  logic        accept, op_ok, push, pop, base_take;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          fifo_empty;

  logic                  write_d;
  logic [31:0]           data_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [15:0]           cnt_d;

  always_comb begin
    b_hi  = '0;
    b_mid = '0;
    b_lo  = '0;
    unique case (FORMAT)
      2'd0: begin b_hi = {5'b0, WRITEREG}; b_mid = {5'b0, READREG1}; b_lo = {5'b0, READREG2}; end
      2'd1: begin b_hi = {5'b0, WRITEREG}; b_lo = IMMEDIATE; end
      2'd2: begin b_hi = OFFSET; b_mid = {5'b0, READREG1}; b_lo = {5'b0, READREG2}; end
      default: b_hi = OFFSET;
    endcase
  end
  assign word = {OPCODE, b_hi, b_mid, b_lo};

  assign accept     = IN_VALID && IN_READY;
  assign push       = accept && op_ok;
  assign fifo_empty = (count == '0);
  assign IDLE       = (state_q == S_IDLE) && fifo_empty;
  assign base_take  = IDLE && BASE_LOAD;

`ifdef ENC_OPCODE_CHECK_EN
  assign op_ok = {24'd0, OPCODE} < 32'(NUM_OPCODES);
  // Set wins over clear so a bad bundle alongside BASE_LOAD is still flagged.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)              ERR <= 1'b0;
    else if (accept && !op_ok) ERR <= 1'b1;
    else if (base_take)        ERR <= 1'b0;
  end
`else
  assign op_ok = 1'b1;
  assign ERR   = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= word;
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      IN_READY <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count    <= count_next;
      IN_READY <= (count_next != CW'(FIFO_DEPTH));
    end
  end

  // The word under write stays at the FIFO head until completion, so the
  // follow-on word (if any) sits one slot behind it.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    write_d = MEM_WRITE;
    data_d  = MEM_WRITEDATA;
    addr_d  = MEM_ADDRESS;
    cnt_d   = WORD_COUNT;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          write_d = 1'b1;
          data_d  = fifo_mem[rd_ptr];
          state_d = S_WRITE;
        end else if (BASE_LOAD) begin
          addr_d = BASE_ADDR & ~ADDR_WIDTH'(3);
          cnt_d  = '0;
        end
      end
      S_WRITE: begin
        if (!MEM_BUSYWAIT) begin
          pop    = 1'b1;
          addr_d = MEM_ADDRESS + ADDR_WIDTH'(4);
          cnt_d  = (WORD_COUNT == 16'hFFFF) ? WORD_COUNT : WORD_COUNT + 16'd1;
          if (count > CW'(1)) begin
            data_d = fifo_mem[rd_ptr + PW'(1)];
          end else begin
            write_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= S_IDLE;
      MEM_WRITE     <= 1'b0;
      MEM_WRITEDATA <= '0;
      MEM_ADDRESS   <= '0;
      WORD_COUNT    <= '0;
    end else begin
      state_q       <= state_d;
      MEM_WRITE     <= write_d;
      MEM_WRITEDATA <= data_d;
      MEM_ADDRESS   <= addr_d;
      WORD_COUNT    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: packing table, directed corner sequences,
// and randomized traffic against a queue-based scoreboard. Honours ENC_OPCODE_CHECK_EN.
module tb_instr_encoder_loader;
  logic        CLK = 1'b0, RESET_N = 1'b1, IN_VALID = 1'b0, IN_READY;
  logic [1:0]  FORMAT = '0;
  logic [7:0]  OPCODE = '0, IMMEDIATE = '0, OFFSET = '0;
  logic [2:0]  WRITEREG = '0, READREG1 = '0, READREG2 = '0;
  logic        BASE_LOAD = 1'b0, MEM_BUSYWAIT = 1'b0;
  logic [9:0]  BASE_ADDR = '0, MEM_ADDRESS;
  logic        MEM_WRITE, IDLE, ERR;
  logic [31:0] MEM_WRITEDATA;
  logic [15:0] WORD_COUNT;

  instr_encoder_loader dut (
    .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .FORMAT(FORMAT), .OPCODE(OPCODE), .WRITEREG(WRITEREG), .READREG1(READREG1),
    .READREG2(READREG2), .IMMEDIATE(IMMEDIATE), .OFFSET(OFFSET),
    .BASE_LOAD(BASE_LOAD), .BASE_ADDR(BASE_ADDR), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .WORD_COUNT(WORD_COUNT), .IDLE(IDLE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] fmt;
    logic [7:0] op;
    logic [2:0] wr, r1, r2;
    logic [7:0] imm, off;
  } bundle_t;
  typedef struct { bundle_t b; logic [31:0] exp; } vec_t;

  bundle_t     pend[$];
  logic [31:0] expq[$];
  logic [9:0]  wr_addrs[$];
  logic [9:0]  ma = '0;
  logic [15:0] mc = '0;
  bit          exp_err = 1'b0;
  int          n_pass = 0, n_chk = 0, got_n = 0;
  logic [31:0] last_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
  endtask

  // Reference packing from the field layout, as plain positional arithmetic.
  function automatic logic [31:0] ref_pack(input bundle_t b);
    logic [31:0] hi, mid, lo;
    case (b.fmt)
      2'd0:    begin hi = 32'(b.wr);  mid = 32'(b.r1); lo = 32'(b.r2);  end
      2'd1:    begin hi = 32'(b.wr);  mid = 0;         lo = 32'(b.imm); end
      2'd2:    begin hi = 32'(b.off); mid = 32'(b.r1); lo = 32'(b.r2);  end
      default: begin hi = 32'(b.off); mid = 0;         lo = 0;          end
    endcase
    return 32'(b.op) * 32'h0100_0000 + hi * 32'h1_0000 + mid * 32'h100 + lo;
  endfunction

  function automatic bundle_t rnd_bundle(input bit legal_op);
    bundle_t b;
    b.fmt = 2'($urandom_range(0, 3));
    b.op  = legal_op ? 8'($urandom_range(0, 11)) : 8'($urandom_range(0, 255));
    b.wr  = 3'($urandom); b.r1 = 3'($urandom); b.r2 = 3'($urandom);
    b.imm = 8'($urandom); b.off = 8'($urandom);
    return b;
  endfunction

  task automatic accept(input bundle_t b);
`ifdef ENC_OPCODE_CHECK_EN
    if (b.op >= 8'd12) begin exp_err = 1'b1; return; end
`endif
    expq.push_back(ref_pack(b));
  endtask

  // One clock: offer the head of pend; it transfers at the next edge if IN_READY is high now.
  task automatic cycle();
    @(posedge CLK); #1;
    BASE_LOAD = 1'b0;
    if (pend.size() > 0) begin
      FORMAT = pend[0].fmt; OPCODE = pend[0].op; WRITEREG = pend[0].wr;
      READREG1 = pend[0].r1; READREG2 = pend[0].r2;
      IMMEDIATE = pend[0].imm; OFFSET = pend[0].off;
      IN_VALID = 1'b1;
      if (IN_READY) begin accept(pend[0]); void'(pend.pop_front()); end
    end else begin
      IN_VALID = 1'b0;
      OPCODE = 8'($urandom); IMMEDIATE = 8'($urandom);
    end
  endtask

  task automatic base_load(input logic [9:0] a, input bit honoured);
    cycle();
    BASE_LOAD = 1'b1; BASE_ADDR = a;
    if (honoured) begin ma = a & 10'h3FC; mc = '0; exp_err = 1'b0; end
  endtask

  task automatic drain(input string nm);
    bit done = 1'b0;
    MEM_BUSYWAIT = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      cycle();
      done = (pend.size() == 0) && (expq.size() == 0) && IDLE;
    end
    cycle();
    chk({nm, "_drained"}, 32'(done), 32'd1);
    chk({nm, "_word_count"}, 32'(WORD_COUNT), 32'(mc));
    chk({nm, "_address"}, 32'(MEM_ADDRESS), 32'(ma));
    chk({nm, "_err"}, 32'(ERR), 32'(exp_err));
  endtask

  // Scoreboard: a write completes at the edge following a negedge with MEM_WRITE=1 and no busywait.
  initial begin
    bit prev_w = 1'b0, prev_busy = 1'b0;
    logic [9:0]  prev_a = '0;
    logic [31:0] prev_d = '0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        prev_w = 1'b0;
      end else begin
        if (prev_w && prev_busy) begin
          chk("stable_write", 32'(MEM_WRITE), 32'd1);
          chk("stable_addr", 32'(MEM_ADDRESS), 32'(prev_a));
          chk("stable_data", MEM_WRITEDATA, prev_d);
        end
        if (MEM_WRITE && !MEM_BUSYWAIT) begin
          if (expq.size() == 0) begin
            chk("unexpected_write", MEM_WRITEDATA, 32'hxxxx_xxxx);
          end else begin
            chk("wr_data", MEM_WRITEDATA, expq[0]);
            chk("wr_addr", 32'(MEM_ADDRESS), 32'(ma));
            void'(expq.pop_front());
          end
          wr_addrs.push_back(MEM_ADDRESS);
          last_data = MEM_WRITEDATA;
          ma = ma + 10'd4;
          mc = (mc == 16'hFFFF) ? mc : mc + 16'd1;
          got_n++;
        end
        prev_w = MEM_WRITE; prev_busy = MEM_BUSYWAIT;
        prev_a = MEM_ADDRESS; prev_d = MEM_WRITEDATA;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected done", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   n0;
    tbl[0] = '{'{2'd0, 8'h02, 3'd3, 3'd1, 3'd2, 8'h00, 8'h00}, 32'h02030102};
    tbl[1] = '{'{2'd1, 8'h00, 3'd4, 3'd7, 3'd7, 8'hFF, 8'hAA}, 32'h000400FF};
    tbl[2] = '{'{2'd2, 8'h07, 3'd7, 3'd1, 3'd5, 8'h55, 8'hFE}, 32'h07FE0105};
    tbl[3] = '{'{2'd3, 8'h06, 3'd7, 3'd7, 3'd7, 8'h99, 8'h03}, 32'h06030000};
    tbl[4] = '{'{2'd0, 8'h0B, 3'd7, 3'd7, 3'd7, 8'h11, 8'h22}, 32'h0B070707};
    tbl[5] = '{'{2'd1, 8'h0A, 3'd0, 3'd6, 3'd5, 8'h80, 8'h44}, 32'h0A000080};

    // Reset values while asserted, then IN_READY rises on the first edge after release.
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    chk("rst_mem_address", 32'(MEM_ADDRESS), 32'd0);
    chk("rst_mem_writedata", MEM_WRITEDATA, 32'd0);
    chk("rst_word_count", 32'(WORD_COUNT), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_in_ready", 32'(IN_READY), 32'd0);
    chk("rst_idle", 32'(IDLE), 32'd1);
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    cycle();
    chk("post_rst_in_ready", 32'(IN_READY), 32'd1);

    // Latency: MEM_WRITE is low right after the transfer edge and high one edge later.
    base_load(10'h040, 1'b1);
    pend.push_back(tbl[0].b);
    cycle();
    cycle();
    chk("lat_write_low", 32'(MEM_WRITE), 32'd0);
    cycle();
    chk("lat_write_high", 32'(MEM_WRITE), 32'd1);
    chk("lat_data", MEM_WRITEDATA, 32'h02030102);
    chk("lat_addr", 32'(MEM_ADDRESS), 32'h040);
    drain("first");
    chk("first_count_1", 32'(WORD_COUNT), 32'd1);
    chk("first_addr_44", 32'(MEM_ADDRESS), 32'h044);

    // Packing table.
    for (int i = 0; i < 6; i++) begin
      pend.push_back(tbl[i].b);
      drain("tbl");
      chk($sformatf("pack_vec%0d", i), last_data, tbl[i].exp);
    end

    // Backpressure: memory busy while six bundles are offered.
    MEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 6; i++) pend.push_back(rnd_bundle(1'b1));
    repeat (8) cycle();
    chk("busy_accepted", 32'(6 - pend.size()), 32'd4);
    chk("busy_in_ready", 32'(IN_READY), 32'd0);
    chk("busy_mem_write", 32'(MEM_WRITE), 32'd1);
    n0 = got_n;
    MEM_BUSYWAIT = 1'b0;
    repeat (6) cycle();
    chk("b2b_writes", 32'(got_n - n0), 32'd6);
    chk("b2b_idle", 32'(IDLE), 32'd1);
    drain("busy");

    // Reset mid-write with three words queued.
    MEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) pend.push_back(rnd_bundle(1'b1));
    repeat (5) cycle();
    chk("midrst_pre_write", 32'(MEM_WRITE), 32'd1);
    RESET_N = 1'b0;
    #1;
    chk("midrst_write", 32'(MEM_WRITE), 32'd0);
    chk("midrst_idle", 32'(IDLE), 32'd1);
    expq.delete(); ma = '0; mc = '0; exp_err = 1'b0;
    n0 = got_n;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    MEM_BUSYWAIT = 1'b0;
    repeat (10) cycle();
    chk("midrst_no_writes", 32'(got_n - n0), 32'd0);
    chk("midrst_idle_after", 32'(IDLE), 32'd1);
    chk("midrst_count", 32'(WORD_COUNT), 32'd0);
    chk("midrst_addr", 32'(MEM_ADDRESS), 32'd0);

    // Illegal opcode followed by a legal one.
    n0 = got_n;
    pend.push_back('{2'd1, 8'h0C, 3'd1, 3'd0, 3'd0, 8'h12, 8'h00});
    pend.push_back('{2'd0, 8'h01, 3'd2, 3'd3, 3'd4, 8'h00, 8'h00});
    drain("opc");
`ifdef ENC_OPCODE_CHECK_EN
    chk("opc_writes", 32'(got_n - n0), 32'd1);
    chk("opc_word", last_data, 32'h01020304);
    chk("opc_count", 32'(WORD_COUNT), 32'd1);
    chk("opc_err", 32'(ERR), 32'd1);
`else
    chk("opc_writes", 32'(got_n - n0), 32'd2);
    chk("opc_word", last_data, 32'h01020304);
    chk("opc_count", 32'(WORD_COUNT), 32'd2);
    chk("opc_err", 32'(ERR), 32'd0);
`endif

    // Address wrap from the top of memory; a BASE_LOAD mid-stream is ignored.
    base_load(10'h3FE, 1'b1);
    wr_addrs.delete();
    MEM_BUSYWAIT = 1'b1;
    pend.push_back(rnd_bundle(1'b1));
    pend.push_back(rnd_bundle(1'b1));
    repeat (4) cycle();
    base_load(10'h100, 1'b0);
    drain("wrap");
    chk("wrap_n", 32'(wr_addrs.size()), 32'd2);
    if (wr_addrs.size() == 2) begin
      chk("wrap_addr0", 32'(wr_addrs[0]), 32'h3FC);
      chk("wrap_addr1", 32'(wr_addrs[1]), 32'h000);
    end
    chk("wrap_final_addr", 32'(MEM_ADDRESS), 32'h004);
    chk("wrap_count", 32'(WORD_COUNT), 32'd2);

    // Randomized traffic with random memory stalls.
    base_load(10'(($urandom_range(0, 255)) * 4), 1'b1);
    for (int i = 0; i < 200; i++) pend.push_back(rnd_bundle(1'b0));
    for (int i = 0; i < 5000 && pend.size() > 0; i++) begin
      MEM_BUSYWAIT = ($urandom_range(0, 2) == 0);
      cycle();
    end
    drain("random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
